// File: rtl/turn_countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_timer_pkg
//  Description : Shared types and widths for the per-turn countdown timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_timer_pkg;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_RUN     = 2'd1,
        T_EXPIRED = 2'd2
    } timer_state_t;

    localparam int SEC_W = 4;

endpackage : game_timer_pkg
`default_nettype wire

// File: rtl/turn_countdown_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : turn_countdown_timer_if
//  Description : Control/status bundle between game FSM, display and timer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface turn_countdown_timer_if;
    import game_timer_pkg::*;

    logic             start;
    logic             stop;
    logic             hold;
    logic [SEC_W-1:0] seconds;
    logic             running;
    logic             sec_tick;
    logic             timeout;

    modport master (
        output start, stop, hold,
        input  seconds, running, sec_tick, timeout
    );

    modport slave (
        input  start, stop, hold,
        output seconds, running, sec_tick, timeout
    );

endinterface : turn_countdown_timer_if
`default_nettype wire

// File: rtl/turn_countdown_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Free-running divider producing a one-cycle tick every CLK_HZ
//                enabled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      tick
);

    localparam int              c_W    = $clog2(CLK_HZ);
    localparam logic [c_W-1:0]  c_LAST = c_W'(CLK_HZ - 1);

    logic [c_W-1:0] r_count;

    // Tick is combinational so the owner registers it alongside its own state.
    assign tick = enable && (r_count == c_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= tick ? '0 : r_count + c_W'(1);
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/turn_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : turn_countdown_timer
//  Description : Per-turn seconds countdown with running/expired status and
//                one-cycle tick/timeout pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module turn_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int START_SECONDS = 10
) (
    input  wire logic               clk,
    input  wire logic               rst,
    turn_countdown_timer_if.slave   bus
);

    localparam logic [1:0]       c_ST_IDLE    = 2'(T_IDLE);
    localparam logic [1:0]       c_ST_RUN     = 2'(T_RUN);
    localparam logic [1:0]       c_ST_EXPIRED = 2'(T_EXPIRED);
    localparam logic [SEC_W-1:0] c_START      = SEC_W'(START_SECONDS);

    logic [1:0]       r_state;
    logic [SEC_W-1:0] r_seconds;
    logic             r_running;
    logic             r_sec_tick;
    logic             r_timeout;

    logic             w_clear;
    logic             w_enable;
    logic             w_tick;

    // Any reload or non-running state parks the divider at zero.
    assign w_clear  = bus.stop || bus.start || (r_state != c_ST_RUN);
    assign w_enable = (r_state == c_ST_RUN) && !bus.hold;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .enable (w_enable),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_seconds  <= c_START;
            r_running  <= 1'b0;
            r_sec_tick <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_sec_tick <= 1'b0;
            r_timeout  <= 1'b0;
            if (bus.stop) begin
                r_state   <= c_ST_IDLE;
                r_seconds <= c_START;
                r_running <= 1'b0;
            end else if (bus.start) begin
                r_state   <= c_ST_RUN;
                r_seconds <= c_START;
                r_running <= 1'b1;
            end else if ((r_state == c_ST_RUN) && w_tick) begin
                r_sec_tick <= 1'b1;
                if (r_seconds <= SEC_W'(1)) begin
                    r_seconds <= '0;
                    r_timeout <= 1'b1;
                    r_state   <= c_ST_EXPIRED;
                    r_running <= 1'b0;
                end else begin
                    r_seconds <= r_seconds - SEC_W'(1);
                end
            end
        end
    end

    assign bus.seconds  = r_seconds;
    assign bus.running  = r_running;
    assign bus.sec_tick = r_sec_tick;
    assign bus.timeout  = r_timeout;

endmodule : turn_countdown_timer
`default_nettype wire

// File: tb/tb_turn_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turn_countdown_timer
//  Description : Directed self-checking bench, CLK_HZ=4, START_SECONDS=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_countdown_timer;

    localparam int c_CLK_HZ = 4;
    localparam int c_START  = 3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    turn_countdown_timer_if tif ();

    turn_countdown_timer #(
        .CLK_HZ        (c_CLK_HZ),
        .START_SECONDS (c_START)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {seconds, running, sec_tick, timeout}
    logic [6:0] obs;
    assign obs = {tif.seconds, tif.running, tif.sec_tick, tif.timeout};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        tif.start = 1'b0; tif.stop = 1'b0; tif.hold = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        exp = {4'd3, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_in: got %b want %b", obs, exp);
        end
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL idle k=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_countdown();
        logic [6:0] exp;
        tif.start = 1'b1; step(); tif.start = 1'b0;
        exp = {4'd3, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL cd_start: got %b want %b", obs, exp);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = {4'(3 - k / 4), (k < 12), (k % 4 == 0), (k == 12)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL countdown k=%0d: got %b want %b", k, obs, exp);
            end
        end
        exp = {4'd0, 1'b0, 1'b0, 1'b0};
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL expired k=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_hold();
        logic [6:0] exp;
        tif.start = 1'b1; step(); tif.start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tif.hold = (k >= 3 && k <= 12);
            step();
            exp = {(k < 14) ? 4'd3 : (k < 18) ? 4'd2 : 4'd1, 1'b1,
                   (k == 14 || k == 18), 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL hold k=%0d: got %b want %b", k, obs, exp);
            end
        end
        tif.hold = 1'b0;
        tif.stop = 1'b1; step(); tif.stop = 1'b0;
        exp = {4'd3, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL hold_stop: got %b want %b", obs, exp);
        end
    endtask

    task automatic test_restart();
        logic [6:0] exp;
        logic [3:0] s;
        tif.start = 1'b1; step(); tif.start = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tif.start = (k == 7);
            step();
            if (k < 4)       s = 4'd3;
            else if (k < 7)  s = 4'd2;
            else if (k < 11) s = 4'd3;
            else if (k < 15) s = 4'd2;
            else if (k < 19) s = 4'd1;
            else             s = 4'd0;
            exp = {s, (k < 19), (k == 4 || k == 11 || k == 15 || k == 19), (k == 19)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL restart k=%0d: got %b want %b", k, obs, exp);
            end
        end
        tif.start = 1'b0;
    endtask

    task automatic test_priority();
        logic [6:0] exp;
        tif.start = 1'b1; step(); tif.start = 1'b0;
        step(); step();
        tif.start = 1'b1; tif.stop = 1'b1; step();
        tif.start = 1'b0; tif.stop = 1'b0;
        exp = {4'd3, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k <= 5; k++) begin
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL start_stop k=%0d: got %b want %b", k, obs, exp);
            end
            step();
        end
        tif.start = 1'b1; step(); tif.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tif.start = (k == 4);
            step();
            exp = {(k < 8) ? 4'd3 : 4'd2, 1'b1, (k == 8), 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL start_on_tick k=%0d: got %b want %b", k, obs, exp);
            end
        end
        tif.start = 1'b0;
        tif.stop = 1'b1; step(); tif.stop = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [6:0] exp;
        tif.start = 1'b1; step(); tif.start = 1'b0;
        repeat (5) step();
        exp = {4'd2, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL pre_rst: got %b want %b", obs, exp);
        end
        #3 rst = 1'b0;
        #1;
        exp = {4'd3, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL async_rst: got %b want %b", obs, exp);
        end
        step();
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL post_rst k=%0d: got %b want %b", k, obs, exp);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tif.start = 1'b0; tif.stop = 1'b0; tif.hold = 1'b0;
        rst = 1'b0;
        test_reset();
        test_countdown();
        test_hold();
        test_restart();
        test_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_turn_countdown_timer
`default_nettype wire
